// File: rtl/rv_trap_ctrl_if.sv
// rtl/rv_trap_ctrl_if.sv - execute/CSR/fetch signal bundle for the machine-mode trap controller
interface rv_trap_ctrl_if;
    logic [2:0]  i_pend;
    logic [2:0]  i_en;
    logic        i_ebreak;
    logic        i_ecall;
    logic        i_mret;
    logic [31:0] i_pc;
    logic [31:0] i_mtvec;
    logic        i_csr_we;
    logic [1:0]  i_csr_wdata;
    logic        i_drain_ack;
    logic        o_drain_req;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic        o_mepc_we;
    logic [31:0] o_mepc;
    logic        o_mcause_we;
    logic [31:0] o_mcause;
    logic [1:0]  o_mstatus;
    logic        o_busy;

    modport master (
        output i_pend, i_en, i_ebreak, i_ecall, i_mret, i_pc, i_mtvec,
               i_csr_we, i_csr_wdata, i_drain_ack,
        input  o_drain_req, o_redirect, o_redirect_pc, o_mepc_we, o_mepc,
               o_mcause_we, o_mcause, o_mstatus, o_busy
    );

    modport slave (
        input  i_pend, i_en, i_ebreak, i_ecall, i_mret, i_pc, i_mtvec,
               i_csr_we, i_csr_wdata, i_drain_ack,
        output o_drain_req, o_redirect, o_redirect_pc, o_mepc_we, o_mepc,
               o_mcause_we, o_mcause, o_mstatus, o_busy
    );
endinterface

// File: rtl/rv_trap_ctrl.sv
// rtl/rv_trap_ctrl.sv - machine-mode trap entry/return sequencer; RV_TRAP_VECTORED_EN enables vectored interrupt dispatch
module rv_trap_ctrl #(
    parameter int RET_LAT = 1
) (
    input logic           i_clk,
    input logic           i_reset_n,
    rv_trap_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, DRAIN, ENTER, REDIR, RET} state_t;

    localparam logic [1:0] RET_LAST = 2'(RET_LAT - 1);

    state_t      state, nxt;
    logic        mie, mpie;
    logic [31:0] mepc, mcause, redirect_pc;
    logic [1:0]  ret_cnt;
    logic [2:0]  pend_en;
    logic        irq, trap_req;
    logic [31:0] cause_sel, target;
    logic        drain_req, redirect, csr_strobe, busy;

    assign pend_en  = bus.i_pend & bus.i_en;
    assign irq      = mie & (|pend_en);
    assign trap_req = bus.i_ebreak | bus.i_ecall | irq;

    // Exceptions outrank interrupts; among interrupts ext > soft > timer.
    always_comb begin
        cause_sel = 32'd0;
        if (bus.i_ebreak)     cause_sel = 32'd3;
        else if (bus.i_ecall) cause_sel = 32'd11;
        else if (pend_en[2])  cause_sel = 32'h8000_000B;
        else if (pend_en[0])  cause_sel = 32'h8000_0003;
        else if (pend_en[1])  cause_sel = 32'h8000_0007;
    end

`ifdef RV_TRAP_VECTORED_EN
    always_comb begin
        target = {bus.i_mtvec[31:2], 2'b00};
        if (bus.i_mtvec[1:0] == 2'b01 && cause_sel[31])
            target = {bus.i_mtvec[31:2], 2'b00} + {22'd0, cause_sel[7:0], 2'b00};
    end
`else
    wire unused_mode = &{1'b0, bus.i_mtvec[1:0]};
    assign target = {bus.i_mtvec[31:2], 2'b00};
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= nxt;
    end

    always_comb begin
        nxt        = state;
        drain_req  = 1'b0;
        redirect   = 1'b0;
        csr_strobe = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (trap_req)        nxt = DRAIN;
                else if (bus.i_mret) nxt = REDIR;
            end
            DRAIN: begin
                drain_req = 1'b1;
                if (bus.i_drain_ack) nxt = ENTER;
            end
            ENTER: begin
                csr_strobe = 1'b1;
                nxt        = REDIR;
            end
            REDIR: begin
                redirect = 1'b1;
                nxt      = RET;
            end
            RET: begin
                if (ret_cnt == RET_LAST) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Trap context is captured at acceptance; DRAIN can only exit via ENTER or reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            mie         <= 1'b0;
            mpie        <= 1'b0;
            mepc        <= 32'd0;
            mcause      <= 32'd0;
            redirect_pc <= 32'd0;
            ret_cnt     <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_req) begin
                        mepc        <= bus.i_pc;
                        mcause      <= cause_sel;
                        redirect_pc <= target;
                        if (bus.i_csr_we) {mpie, mie} <= bus.i_csr_wdata;
                    end else if (bus.i_mret) begin
                        redirect_pc <= mepc;
                        mie         <= mpie;
                        mpie        <= 1'b1;
                    end else if (bus.i_csr_we) begin
                        {mpie, mie} <= bus.i_csr_wdata;
                    end
                end
                ENTER: begin
                    mpie <= mie;
                    mie  <= 1'b0;
                end
                REDIR:   ret_cnt <= 2'd0;
                RET:     ret_cnt <= ret_cnt + 2'd1;
                default: ;
            endcase
        end
    end

    assign bus.o_drain_req   = drain_req;
    assign bus.o_redirect    = redirect;
    assign bus.o_redirect_pc = redirect_pc;
    assign bus.o_mepc_we     = csr_strobe;
    assign bus.o_mcause_we   = csr_strobe;
    assign bus.o_mepc        = mepc;
    assign bus.o_mcause      = mcause;
    assign bus.o_mstatus     = {mpie, mie};
    assign bus.o_busy        = busy;
endmodule

// File: tb/tb_rv_trap_ctrl.sv
// tb/tb_rv_trap_ctrl.sv - directed and randomized bench for rv_trap_ctrl against a transaction-level model
module tb_rv_trap_ctrl;
    localparam int RET_LAT = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv_trap_ctrl_if bus ();
    rv_trap_ctrl #(.RET_LAT(RET_LAT)) dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));

    int total = 0;
    int bad = 0;
    bit m_mie, m_mpie;
    logic [31:0] m_mepc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses;
        bus.i_ebreak = 0; bus.i_ecall = 0; bus.i_mret = 0;
        bus.i_csr_we = 0; bus.i_csr_wdata = 0; bus.i_drain_ack = 0;
        bus.i_pc = 0; bus.i_mtvec = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_drain"}, 32'(bus.o_drain_req), 0);
        chk({tag, "_redir"}, 32'(bus.o_redirect), 0);
        chk({tag, "_mepcwe"}, 32'(bus.o_mepc_we), 0);
        chk({tag, "_mcausewe"}, 32'(bus.o_mcause_we), 0);
        chk({tag, "_busy"}, 32'(bus.o_busy), 0);
        chk({tag, "_mstatus"}, 32'(bus.o_mstatus), 0);
        chk({tag, "_mepc"}, bus.o_mepc, 0);
        chk({tag, "_mcause"}, bus.o_mcause, 0);
        chk({tag, "_rpc"}, bus.o_redirect_pc, 0);
    endtask

    task automatic finish_ret(input string tag);
        clear_pulses();
        tick();
        chk({tag, "_ret_busy"}, 32'(bus.o_busy), 1);
        chk({tag, "_ret_redir"}, 32'(bus.o_redirect), 0);
        repeat (RET_LAT - 1) tick();
        tick();
        chk({tag, "_idle"}, 32'(bus.o_busy), 0);
    endtask

    // One IDLE-cycle request followed by the full sequence the model predicts.
    task automatic step(input bit eb, input bit ec, input bit mr,
                        input logic [2:0] pend, input logic [2:0] en,
                        input logic [31:0] pc, input logic [31:0] mtvec,
                        input bit cwe, input logic [1:0] wd,
                        input int ack_dly, input string tag);
        logic [2:0]  pe;
        bit          trap;
        logic [31:0] cause, tgt;
        pe = pend & en;
        trap = eb || ec || (m_mie && pe != 0);
        if (eb)         cause = 32'd3;
        else if (ec)    cause = 32'd11;
        else if (pe[2]) cause = 32'h8000_000B;
        else if (pe[0]) cause = 32'h8000_0003;
        else            cause = 32'h8000_0007;
        tgt = {mtvec[31:2], 2'b00};
`ifdef RV_TRAP_VECTORED_EN
        if (mtvec[1:0] == 2'b01 && cause[31]) tgt = tgt + 4 * cause[7:0];
`endif
        bus.i_ebreak = eb; bus.i_ecall = ec; bus.i_mret = mr;
        bus.i_pend = pend; bus.i_en = en; bus.i_pc = pc; bus.i_mtvec = mtvec;
        bus.i_csr_we = cwe; bus.i_csr_wdata = wd; bus.i_drain_ack = 0;
        tick();
        if (trap) begin
            if (cwe) {m_mpie, m_mie} = wd;
            chk({tag, "_drain_req"}, 32'(bus.o_drain_req), 1);
            chk({tag, "_mcause_lat"}, bus.o_mcause, cause);
            chk({tag, "_mepc_lat"}, bus.o_mepc, pc);
            bus.i_ebreak = 1'($urandom); bus.i_ecall = 1'($urandom); bus.i_mret = 1'($urandom);
            bus.i_pc = $urandom; bus.i_mtvec = $urandom;
            bus.i_csr_we = 1'($urandom); bus.i_csr_wdata = 2'($urandom);
            for (int i = 0; i < ack_dly; i++) begin
                tick();
                chk({tag, "_drain_hold"}, 32'(bus.o_drain_req), 1);
            end
            bus.i_drain_ack = 1;
            tick();
            bus.i_drain_ack = 0;
            chk({tag, "_mepc_we"}, 32'(bus.o_mepc_we), 1);
            chk({tag, "_mcause_we"}, 32'(bus.o_mcause_we), 1);
            chk({tag, "_enter_mepc"}, bus.o_mepc, pc);
            chk({tag, "_enter_mcause"}, bus.o_mcause, cause);
            chk({tag, "_enter_drain"}, 32'(bus.o_drain_req), 0);
            chk({tag, "_enter_mstatus"}, 32'(bus.o_mstatus), 32'({m_mpie, m_mie}));
            m_mpie = m_mie; m_mie = 0; m_mepc = pc;
            tick();
            chk({tag, "_redirect"}, 32'(bus.o_redirect), 1);
            chk({tag, "_target"}, bus.o_redirect_pc, tgt);
            chk({tag, "_redir_we"}, 32'(bus.o_mepc_we), 0);
            chk({tag, "_trap_mstatus"}, 32'(bus.o_mstatus), 32'({m_mpie, m_mie}));
            finish_ret(tag);
        end else if (mr) begin
            m_mie = m_mpie; m_mpie = 1;
            chk({tag, "_mret_redirect"}, 32'(bus.o_redirect), 1);
            chk({tag, "_mret_target"}, bus.o_redirect_pc, m_mepc);
            chk({tag, "_mret_we"}, 32'({bus.o_mepc_we, bus.o_mcause_we}), 0);
            chk({tag, "_mret_drain"}, 32'(bus.o_drain_req), 0);
            chk({tag, "_mret_mstatus"}, 32'(bus.o_mstatus), 32'({m_mpie, m_mie}));
            finish_ret(tag);
        end else begin
            if (cwe) {m_mpie, m_mie} = wd;
            chk({tag, "_stay_idle"}, 32'(bus.o_busy), 0);
            chk({tag, "_csr_mstatus"}, 32'(bus.o_mstatus), 32'({m_mpie, m_mie}));
            clear_pulses();
        end
    endtask

    initial begin
        clear_pulses();
        bus.i_pend = 0; bus.i_en = 0;
        m_mie = 0; m_mpie = 0; m_mepc = 0;
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1;

        step(0, 0, 0, 3'b000, 3'b000, 32'h0, 32'h0, 1, 2'b01, 0, "csr_wr");
        step(0, 0, 0, 3'b100, 3'b100, 32'h40, 32'h100, 0, 2'b00, 2, "ext_irq");
        step(0, 0, 1, 3'b000, 3'b000, 32'h0, 32'h0, 0, 2'b00, 0, "mret");
        step(1, 0, 0, 3'b100, 3'b100, 32'h80, 32'h300, 0, 2'b00, 1, "ebreak_vs_irq");
        step(0, 0, 0, 3'b100, 3'b100, 32'h0, 32'h300, 0, 2'b00, 0, "irq_masked");
        step(0, 0, 1, 3'b100, 3'b100, 32'h0, 32'h300, 0, 2'b00, 0, "mret_restore");
        step(0, 0, 0, 3'b100, 3'b100, 32'hC4, 32'h300, 0, 2'b00, 0, "irq_after_mret");
        bus.i_pend = 0; bus.i_en = 0;
        step(0, 1, 1, 3'b000, 3'b000, 32'h1234, 32'h400, 1, 2'b01, 0, "mret_ecall");

        bus.i_ecall = 1; bus.i_pc = 32'h500; bus.i_mtvec = 32'h600;
        tick();
        chk("rst_drain_pre", 32'(bus.o_drain_req), 1);
        clear_pulses();
        rst_n = 0;
        tick();
        check_all_zero("rst_in_drain");
        m_mie = 0; m_mpie = 0; m_mepc = 0;
        rst_n = 1;
        step(0, 1, 0, 3'b000, 3'b000, 32'h700, 32'h800, 0, 2'b00, 0, "first_after_rst");

        step(0, 0, 0, 3'b000, 3'b000, 32'h0, 32'h0, 1, 2'b01, 0, "csr_wr2");
        step(0, 0, 0, 3'b010, 3'b010, 32'h900, 32'h201, 0, 2'b00, 0, "timer_mode");
        step(0, 0, 0, 3'b000, 3'b000, 32'h0, 32'h0, 1, 2'b01, 0, "csr_wr3");
        step(0, 0, 0, 3'b011, 3'b111, 32'h904, 32'h201, 0, 2'b00, 0, "soft_vs_timer");

        for (int n = 0; n < 40; n++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                 3'($urandom), 3'($urandom), $urandom & 32'hFFFF_FFFC, $urandom,
                 $urandom_range(0, 2) == 0, 2'($urandom), $urandom_range(0, 3), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rv_trap_ctrl.md
RV_TRAP_CTRL -- requirements
Module: rv_trap_ctrl

Interface
REQ-001 SHALL have parameter RET_LAT, default 1: cycles between o_redirect and return to IDLE (1..3).
REQ-002 SHALL have port i_clk, in, 1: clock; all state updates on rising edge.
REQ-003 SHALL have port i_reset_n, in, 1: reset, synchronous, active-low.
REQ-004 SHALL have ports i_pend in 3 and i_en in 3: {ext, timer, soft} interrupt pending bits (mip) and enable bits (mie).
REQ-005 SHALL have ports i_ebreak, i_ecall, i_mret, each in, 1: single-cycle pulses from execute.
REQ-006 SHALL have ports i_pc in 32 and i_mtvec in 32: PC of the faulting or next instruction, and the trap base register.
REQ-007 SHALL have ports i_csr_we in 1 and i_csr_wdata in 2: software write of {MPIE, MIE} (mstatus bits 7 and 3).
REQ-008 SHALL have ports o_drain_req out 1 and i_drain_ack in 1: pipeline drain handshake.
REQ-009 SHALL have ports o_redirect out 1 and o_redirect_pc out 32: one-cycle fetch redirect with its target.
REQ-010 SHALL have ports o_mepc_we out 1, o_mepc out 32, o_mcause_we out 1, o_mcause out 32: CSR-file update strobes and data.
REQ-011 SHALL have ports o_mstatus out 2 ({MPIE, MIE}) and o_busy out 1 (FSM not IDLE).

Function
REQ-012 SHALL implement FSM states IDLE, DRAIN, ENTER, REDIR, RET.
REQ-013 In IDLE, a trap request SHALL be any of i_ebreak, i_ecall, or an interrupt, where interrupt = MIE & |(i_pend & i_en).
REQ-014 In IDLE, i_mret SHALL go directly to REDIR with o_redirect_pc = held mepc, and on the same edge set MIE <= MPIE and MPIE <= 1.
REQ-015 Cause priority SHALL be: ebreak (cause 3) > ecall (cause 11) > ext interrupt (cause 0x8000000B) > soft (0x80000003) > timer (0x80000007).
REQ-016 Cause and i_pc SHALL be latched on the IDLE->DRAIN edge; later input changes SHALL be ignored until the next return to IDLE.
REQ-017 In DRAIN, o_drain_req SHALL be 1; it SHALL stay 1 until i_drain_ack is sampled high, then the FSM SHALL go to ENTER.
REQ-018 In ENTER, o_mepc_we and o_mcause_we SHALL pulse for exactly one cycle with the latched values, MPIE <= MIE and MIE <= 0, then the FSM SHALL go to REDIR.
REQ-019 In REDIR, o_redirect SHALL be 1 for exactly one cycle, then the FSM SHALL go to RET.
REQ-020 The trap target SHALL be {i_mtvec[31:2], 2'b00}, subject to REQ-033.
REQ-021 RET SHALL hold for RET_LAT cycles (counter), then go to IDLE; no new request SHALL be accepted while in RET.
REQ-022 An exception pulse arriving while not IDLE SHALL be dropped; an interrupt SHALL remain level-sensitive and be re-evaluated in IDLE.
REQ-023 If i_mret and a trap request arrive in the same cycle, the trap SHALL win and i_mret SHALL be dropped.
REQ-024 i_csr_we SHALL update {MPIE, MIE} only in IDLE; ENTER and mret updates SHALL take precedence on the same edge.
REQ-025 o_mepc SHALL present the held mepc continuously; the mret target SHALL use the last value written in ENTER.
REQ-026 The o_mcause width rule: bit 31 = interrupt flag, bits 30:8 = 0, bits 7:0 = code.

Reset
REQ-027 On i_reset_n low at a clock edge, the FSM SHALL go to IDLE regardless of state, including mid-DRAIN.
REQ-028 On reset, o_drain_req, o_redirect, o_mepc_we, o_mcause_we and o_busy SHALL be 0.
REQ-029 On reset, o_mstatus, held mepc and held mcause SHALL be 0.
REQ-030 On reset, o_redirect_pc SHALL be 0 and the RET counter SHALL be 0.
REQ-031 A trap request present on the first cycle after reset release SHALL be accepted.

Configuration
REQ-032 Macro RV_TRAP_VECTORED_EN SHALL control vectored trap dispatch.
REQ-033 With RV_TRAP_VECTORED_EN defined, if i_mtvec[1:0]==01 and the cause is an interrupt, the target SHALL be {i_mtvec[31:2],2'b00} + 4*code.
REQ-034 Without RV_TRAP_VECTORED_EN, the target SHALL always be the direct base, and mode bits SHALL be ignored.

Verification
REQ-035 Scenario: MIE=1, i_en=3'b100, i_pend=3'b100, mtvec=0x100, pc=0x40, ack after 2 cycles -> mcause=0x8000000B, mepc=0x40, redirect to 0x100, MIE=0, MPIE=1.
REQ-036 Scenario: i_ebreak with pending enabled ext interrupt in the same cycle -> mcause=3 (ebreak wins); the interrupt is taken after return to IDLE only if MIE was restored.
REQ-037 Scenario: after REQ-035, i_mret -> redirect to 0x40 in REDIR, MIE=1, MPIE=1, no CSR write strobes.
REQ-038 Scenario: reset asserted in DRAIN with ack never given -> next cycle IDLE, o_drain_req=0, all outputs 0.
REQ-039 Scenario: RV_TRAP_VECTORED_EN defined, mtvec=0x201, timer interrupt -> redirect to 0x21C; with the macro undefined -> redirect to 0x200.
REQ-040 Scenario: i_mret and i_ecall in the same cycle -> trap with mcause=11, mret ignored, MIE cleared.
